a2d_spi_responder: RTL and testbench

- Synthesizable SPI slave model of the 8-channel, 12-bit A2D converter that the IR sensor interface reads through its A2D master.
- Sits on the SS_n/SCLK/MOSI/MISO pins opposite the master and returns per-channel sample values that the bench or a sensor model loads.
- Follows converter pipelining: each frame's response carries the channel addressed in the *previous* frame.
- Used in full-chip sims to close the IR sensing loop without an analog model.

---
 rtl/a2d_spi_responder.sv | 114 +++++++++++
 tb/tb_a2d_spi_responder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/a2d_spi_responder.sv
// a2d_spi_responder: SPI slave model of an 8-channel 12-bit A2D converter.
// Each frame's response carries the sample for the channel addressed in the previous good frame.
module a2d_spi_responder #(
   parameter logic [11:0] RST_VAL     = 12'h000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic        wr_en,
   input  logic [2:0]  wr_chnl,
   input  logic [11:0] wr_data,
   output logic [2:0]  cmd_chnl,
   output logic        frame_done,
   output logic        frame_err
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t                 state_q, state_d;
   logic [SYNC_STAGES:0]   ss_q, sclk_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic [11:0]            regs_q [8];
   logic [4:0]             cnt_q, cnt_d;
   logic [15:0]            tx_q, tx_d;
   logic [13:0]            rx_q, rx_d;
   logic [2:0]             cmd_q, cmd_d;
   logic                   done_q, done_d, err_q, err_d;
   logic                   ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

   assign ss_fall    = ss_q[SYNC_STAGES] & ~ss_q[SYNC_STAGES-1];
   assign ss_rise    = ~ss_q[SYNC_STAGES] & ss_q[SYNC_STAGES-1];
   assign sclk_fall  = sclk_q[SYNC_STAGES] & ~sclk_q[SYNC_STAGES-1];
   assign sclk_rise  = ~sclk_q[SYNC_STAGES] & sclk_q[SYNC_STAGES-1];
   assign mosi_s     = mosi_q[SYNC_STAGES-1];
   assign MISO       = tx_q[15];
   assign cmd_chnl   = cmd_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_q   <= '1;
         sclk_q <= '1;
         mosi_q <= '0;
      end else begin
         ss_q   <= {ss_q[SYNC_STAGES-1:0], SS_n};
         sclk_q <= {sclk_q[SYNC_STAGES-1:0], SCLK};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= RST_VAL;
      end else if (wr_en) begin
         regs_q[wr_chnl] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         cmd_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         cmd_q   <= cmd_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // SS_n rise takes priority over any SCLK edge seen in the same cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      cmd_d   = cmd_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: if (ss_fall) begin
            state_d = SHIFT;
            cnt_d   = '0;
            tx_d    = {4'h0, regs_q[cmd_q]};
         end
         SHIFT: if (ss_rise) begin
            state_d = DONE;
         end else if (sclk_rise) begin
            rx_d  = {rx_q[12:0], mosi_s};
            cnt_d = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
         end else if (sclk_fall && cnt_q != 5'd0) begin
            tx_d = {tx_q[14:0], 1'b0};
         end
         DONE: begin
            state_d = IDLE;
            done_d  = (cnt_q == 5'd16);
            err_d   = (cnt_q != 5'd16);
            cmd_d   = (cnt_q == 5'd16) ? rx_q[13:11] : cmd_q;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_a2d_spi_responder.sv
// tb_a2d_spi_responder: drives SPI frames as a master and checks responses against a channel/memory model.
module tb_a2d_spi_responder;
   localparam int          SS = 2;
   localparam logic [11:0] RV = 12'h3C5;

   logic        clk = 1'b0;
   logic        rst_n, SS_n, SCLK, MOSI, MISO, wr_en;
   logic [2:0]  wr_chnl, cmd_chnl;
   logic [11:0] wr_data;
   logic        frame_done, frame_err;
   int          tests = 0, fails = 0;
   int          done_cnt = 0, err_cnt = 0, wide_cnt = 0;
   logic        done_prev = 1'b0, err_prev = 1'b0;
   logic [11:0] mem [8];
   logic [2:0]  cmd_m;

   always #5 clk = ~clk;

   a2d_spi_responder #(.RST_VAL(RV), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .wr_en(wr_en), .wr_chnl(wr_chnl), .wr_data(wr_data),
      .cmd_chnl(cmd_chnl), .frame_done(frame_done), .frame_err(frame_err)
   );

   always @(posedge clk) begin
      done_cnt  <= done_cnt + (frame_done ? 1 : 0);
      err_cnt   <= err_cnt + (frame_err ? 1 : 0);
      wide_cnt  <= wide_cnt + (((frame_done && done_prev) || (frame_err && err_prev)) ? 1 : 0);
      done_prev <= frame_done;
      err_prev  <= frame_err;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] ch, input logic [11:0] val);
      wr_en = 1'b1; wr_chnl = ch; wr_data = val;
      @(negedge clk);
      wr_en = 1'b0;
      mem[ch] = val;
   endtask

   // Master frame: SCLK falls to present data, rises to sample; optional write strobe during bit wr_bit
   task automatic run(input string tag, input logic [2:0] ch, input int nbits, input int half,
                      input int wr_bit, input logic [2:0] wch, input logic [11:0] wval);
      logic [15:0] tx, rx, exp;
      int d0, e0;
      exp = {4'h0, mem[cmd_m]};
      d0 = done_cnt; e0 = err_cnt;
      tx = 16'($urandom);
      tx[13:11] = ch;
      rx = '0;
      SS_n = 1'b0;
      repeat (half) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = (i < 16) ? tx[15-i] : 1'($urandom);
         if (i == wr_bit) begin wr_en = 1'b1; wr_chnl = wch; wr_data = wval; end
         repeat (half) @(negedge clk);
         wr_en = 1'b0;
         if (i < 16) rx[15-i] = MISO;
         SCLK = 1'b1;
         repeat (half) @(negedge clk);
      end
      SS_n = 1'b1;
      repeat (half + 6) @(negedge clk);
      if (wr_bit >= 0 && wr_bit < nbits) mem[wch] = wval;
      if (nbits == 16) begin
         chk({tag, " data"}, 32'(rx), 32'(exp));
         cmd_m = ch;
      end
      chk({tag, " done"}, 32'(done_cnt - d0), (nbits == 16) ? 32'd1 : 32'd0);
      chk({tag, " err"}, 32'(err_cnt - e0), (nbits == 16) ? 32'd0 : 32'd1);
      chk({tag, " cmd"}, 32'(cmd_chnl), 32'(cmd_m));
   endtask

   function automatic int rh();
      return int'($urandom_range(SS + 5, SS + 2));
   endfunction

   initial begin
      int d0, e0;
      rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      wr_en = 1'b0; wr_chnl = '0; wr_data = '0;
      for (int i = 0; i < 8; i++) mem[i] = RV;
      cmd_m = '0;
      repeat (3) @(negedge clk);
      chk("rst miso", 32'(MISO), 32'd0);
      chk("rst cmd", 32'(cmd_chnl), 32'd0);
      chk("rst done", 32'(frame_done), 32'd0);
      chk("rst err", 32'(frame_err), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      wr(3'd3, 12'hA5C);
      wr(3'd0, 12'h123);
      run("pipe0", 3'd3, 16, 5, -1, 3'd0, 12'h0);
      run("pipe1", 3'd0, 16, 5, -1, 3'd0, 12'h0);

      for (int i = 0; i < 8; i++) wr(3'(i), 12'(12'h100 + i));
      for (int i = 0; i < 8; i++) run($sformatf("sweep%0d", i), 3'(i), 16, rh(), -1, 3'd0, 12'h0);
      run("sweep_tail", 3'd0, 16, rh(), -1, 3'd0, 12'h0);

      run("short", 3'd2, 15, rh(), -1, 3'd0, 12'h0);
      run("long", 3'd4, 20, rh(), -1, 3'd0, 12'h0);
      run("after_err", 3'd6, 16, rh(), -1, 3'd0, 12'h0);

      wr(3'd5, 12'h5AA);
      run("col_pre", 3'd5, 16, 5, -1, 3'd0, 12'h0);
      run("col_cur", 3'd5, 16, 5, 6, 3'd5, 12'hBEE);
      run("col_next", 3'd1, 16, 5, -1, 3'd0, 12'h0);

      for (int i = 0; i < 8; i++) begin
         wr(3'($urandom), 12'($urandom));
         run($sformatf("margin%0d", i), 3'($urandom), 16, SS + 2, -1, 3'd0, 12'h0);
      end
      run("pre_rst", 3'd6, 16, rh(), -1, 3'd0, 12'h0);

      SS_n = 1'b0;
      repeat (6) @(negedge clk);
      SCLK = 1'b0; repeat (5) @(negedge clk);
      SCLK = 1'b1; repeat (5) @(negedge clk);
      SCLK = 1'b0; repeat (5) @(negedge clk);
      d0 = done_cnt; e0 = err_cnt;
      rst_n = 1'b0;
      #1;
      chk("midrst miso", 32'(MISO), 32'd0);
      chk("midrst cmd", 32'(cmd_chnl), 32'd0);
      SS_n = 1'b1; SCLK = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) mem[i] = RV;
      cmd_m = '0;
      repeat (8) @(negedge clk);
      chk("midrst no pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      run("post_rst", 3'd2, 16, rh(), -1, 3'd0, 12'h0);
      run("post_rst2", 3'd7, 16, rh(), -1, 3'd0, 12'h0);
      chk("pulse width", 32'(wide_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
